// File: rtl/btn_conditioner.sv
// btn_conditioner: push-button front end. Each raw button input is
// synchronised into clk, debounced, and turned into a clean level plus
// one-cycle press and release pulses. Channels are fully independent.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   btn_raw      raw, asynchronous, bouncing buttons (active high)
//   btn_level    debounced level
//   btn_press    one-cycle pulse per accepted press (and per repeat)
//   btn_release  one-cycle pulse per accepted release
//
// Optional feature: define BTN_AUTO_REPEAT_EN to emit extra btn_press
// pulses REPEAT_DELAY cycles after a press and then every REPEAT_PERIOD
// cycles while the button stays held. Without it no repeat logic exists.
module btn_conditioner #(
  parameter int unsigned NUM_BTN         = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  localparam bit PARAMS_OK = (DEBOUNCE_CYCLES >= 1) && (REPEAT_DELAY >= 1) &&
                             (REPEAT_PERIOD >= 1);
  if (!PARAMS_OK) begin : g_bad_params
    $error("btn_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_e;

  logic [NUM_BTN-1:0] sync1_q, sync2_q;
  state_e             state_q [NUM_BTN];
  state_e             state_d [NUM_BTN];
  logic [CNT_W-1:0]   cnt_q   [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d   [NUM_BTN];
  logic [NUM_BTN-1:0] level_q, level_d;
  logic [NUM_BTN-1:0] press_q, press_d;
  logic [NUM_BTN-1:0] release_q, release_d;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DELAY_C  = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_PERIOD_C = RPT_W'(REPEAT_PERIOD);

  logic [RPT_W-1:0]   rcnt_q [NUM_BTN];
  logic [RPT_W-1:0]   rcnt_d [NUM_BTN];
  // Set once the first (delayed) repeat has fired; later repeats use the period.
  logic [NUM_BTN-1:0] rep_q, rep_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= RELEASED;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        RELEASED: begin
          if (sync2_q[i]) begin
            state_d[i] = PRESS_WAIT;
            cnt_d[i]   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync2_q[i]) begin
            state_d[i] = RELEASED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
            level_d[i] = 1'b1;
            press_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!sync2_q[i]) begin
            state_d[i] = RELEASE_WAIT;
            cnt_d[i]   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (sync2_q[i]) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i]   = RELEASED;
            cnt_d[i]     = '0;
            level_d[i]   = 1'b0;
            release_d[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          state_d[i] = RELEASED;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  // The repeat counter only advances while a channel remains in PRESSED;
  // every entry into PRESSED (fresh press or bounce-back) sees it at 0.
  always_comb begin
    logic [RPT_W-1:0] rcnt_inc;
    rcnt_inc = '0;
    rep_d    = '0;
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      rcnt_d[i] = '0;
      if (state_q[i] == PRESSED && sync2_q[i]) begin
        rcnt_inc = rcnt_q[i] + RPT_W'(1);
        if (rcnt_inc == (rep_q[i] ? RPT_PERIOD_C : RPT_DELAY_C)) begin
          rep_d[i] = 1'b1;
        end else begin
          rcnt_d[i] = rcnt_inc;
          rep_d[i]  = rep_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q <= '0;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        rcnt_q[i] <= '0;
      end
    end else begin
      rep_q <= rep_d;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
        rcnt_q[i] <= rcnt_d[i];
      end
    end
  end

  // A repeat fires on the cycle the counter would reach its target.
  logic [NUM_BTN-1:0] rpt_fire;
  always_comb begin
    for (int unsigned i = 0; i < NUM_BTN; i++) begin
      rpt_fire[i] = (state_q[i] == PRESSED) && sync2_q[i] &&
                    (rcnt_q[i] + RPT_W'(1) == (rep_q[i] ? RPT_PERIOD_C : RPT_DELAY_C));
    end
  end

  logic [NUM_BTN-1:0] rpt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_q <= '0;
    end else begin
      rpt_q <= rpt_fire;
    end
  end

  assign btn_press = press_q | rpt_q;
`else
  assign btn_press = press_q;
`endif

  assign btn_level   = level_q;
  assign btn_release = release_q;

endmodule
